// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I width codes, FSM states
// and small decode helpers.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        ACC0,
        ACC1,
        RESP
    } state_t;

    // Access size in bytes (1, 2 or 4) from the low two funct3 bits.
    function automatic logic [2:0] size_of(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic is_legal(input logic write, input logic [2:0] funct3);
        if (write)
            return (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
        return (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
               (funct3 == F3_BU) || (funct3 == F3_HU);
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Core request/response handshake plus data_memory port, bundled for the LSU.
interface load_store_unit_if #(
    parameter int ADDR_BITS = 10
);
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_write;
    logic [2:0]           req_funct3;
    logic [31:0]          req_addr;
    logic [31:0]          req_wdata;
    logic                 resp_valid;
    logic [31:0]          resp_rdata;
    logic                 resp_error;
    logic [ADDR_BITS-3:0] mem_address;
    logic [3:0]           mem_byteena;
    logic [31:0]          mem_data;
    logic                 mem_wren;
    logic [31:0]          mem_q;

    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_q,
        output req_ready, resp_valid, resp_rdata, resp_error,
               mem_address, mem_byteena, mem_data, mem_wren
    );

    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_q,
        input  req_ready, resp_valid, resp_rdata, resp_error,
               mem_address, mem_byteena, mem_data, mem_wren
    );
endinterface

// File: rtl/lsu_load_align.sv
// Shifts the assembled {hi,lo} load window down by the byte offset and
// sign/zero-extends to 32 bits according to funct3.
module lsu_load_align (
    input  logic [63:0] i_pair,
    input  logic [1:0]  i_off,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data
);
    logic [31:0] w_shift;
    logic        w_sign;

    always_comb begin
        w_shift = 32'(i_pair >> {i_off, 3'b000});
        w_sign  = 1'b0;
        o_data  = w_shift;
        case (i_funct3[1:0])
            2'b00: begin
                w_sign = ~i_funct3[2] & w_shift[7];
                o_data = {{24{w_sign}}, w_shift[7:0]};
            end
            2'b01: begin
                w_sign = ~i_funct3[2] & w_shift[15];
                o_data = {{16{w_sign}}, w_shift[15:0]};
            end
            default: o_data = w_shift;
        endcase
    end
endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between the memory stage and data_memory; word-crossing
// accesses are split into two consecutive word accesses.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_BITS = 10
) (
    input  logic               clock,
    input  logic               reset_n,
    load_store_unit_if.slave   bus
);
    state_t               r_state, w_next;
    logic                 r_write, r_error;
    logic [2:0]           r_funct3;
    logic [ADDR_BITS-1:0] r_addr;
    logic [31:0]          r_wdata, r_lo, r_rdata;

    logic [1:0]           w_off;
    logic [2:0]           w_size;
    logic [7:0]           w_mask8;
    logic [63:0]          w_wide;
    logic                 w_split;
    logic [ADDR_BITS-3:0] w_word;
    logic [63:0]          w_pair;
    logic [31:0]          w_ext;
    logic [ADDR_BITS-3:0] w_mem_address;
    logic [3:0]           w_mem_byteena;
    logic [31:0]          w_mem_data;
    logic                 w_mem_wren;
    logic                 w_unused_addr;

    assign w_unused_addr = ^bus.req_addr[31:ADDR_BITS];

    assign w_off   = r_addr[1:0];
    assign w_size  = size_of(r_funct3);
    assign w_mask8 = 8'(((8'd1 << w_size) - 8'd1) << w_off);
    assign w_wide  = {32'b0, r_wdata} << {w_off, 3'b000};
    assign w_split = ({1'b0, w_off} + w_size) > 3'd4;
    assign w_word  = r_addr[ADDR_BITS-1:2];

    always_comb begin
        w_next        = r_state;
        w_mem_address = '0;
        w_mem_byteena = '0;
        w_mem_data    = '0;
        w_mem_wren    = 1'b0;
        w_pair        = {32'b0, bus.mem_q};
        case (r_state)
            IDLE: begin
                if (bus.req_valid)
                    w_next = is_legal(bus.req_write, bus.req_funct3) ? ACC0 : RESP;
            end
            ACC0: begin
                w_mem_address = w_word;
                w_mem_byteena = w_mask8[3:0];
                w_mem_data    = w_wide[31:0];
                w_mem_wren    = r_write;
                w_next        = w_split ? ACC1 : RESP;
            end
            ACC1: begin
                w_mem_address = w_word + (ADDR_BITS-2)'(1);
                w_mem_byteena = w_mask8[7:4];
                w_mem_data    = w_wide[63:32];
                w_mem_wren    = r_write;
                w_pair        = {bus.mem_q, r_lo};
                w_next        = RESP;
            end
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    lsu_load_align u_align (
        .i_pair   (w_pair),
        .i_off    (w_off),
        .i_funct3 (r_funct3),
        .o_data   (w_ext)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_write  <= 1'b0;
            r_error  <= 1'b0;
            r_funct3 <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_lo     <= '0;
            r_rdata  <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    if (bus.req_valid) begin
                        r_write  <= bus.req_write;
                        r_funct3 <= bus.req_funct3;
                        r_addr   <= bus.req_addr[ADDR_BITS-1:0];
                        r_wdata  <= bus.req_wdata;
                        r_error  <= ~is_legal(bus.req_write, bus.req_funct3);
                        if (!is_legal(bus.req_write, bus.req_funct3))
                            r_rdata <= '0;
                    end
                end
                ACC0: begin
                    r_lo <= bus.mem_q;
                    if (!w_split)
                        r_rdata <= r_write ? '0 : w_ext;
                end
                ACC1:    r_rdata <= r_write ? '0 : w_ext;
                default: ;
            endcase
        end
    end

    // Outputs are forced quiet while reset is held so an interrupted store stops at once.
    assign bus.req_ready   = reset_n & (r_state == IDLE);
    assign bus.resp_valid  = reset_n & (r_state == RESP);
    assign bus.resp_error  = reset_n & (r_state == RESP) & r_error;
    assign bus.resp_rdata  = reset_n ? r_rdata : '0;
    assign bus.mem_address = reset_n ? w_mem_address : '0;
    assign bus.mem_byteena = reset_n ? w_mem_byteena : '0;
    assign bus.mem_data    = reset_n ? w_mem_data : '0;
    assign bus.mem_wren    = reset_n & w_mem_wren;
endmodule
